// File: rtl/multicycle_datapath.sv
// Multi-cycle RV32 core: datapath and control FSM sharing one memory port for
// fetch and data access. Each memory state waits for mem_ready before it completes.
module multicycle_datapath #(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_PC  = '0,
   parameter int unsigned      REG_COUNT = 32
) (
   input  logic             clk,
   input  logic             reset,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic             mem_ready,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic [4:0]       Debug_Source_select,
   output logic [WIDTH-1:0] Debug_out,
   output logic [WIDTH-1:0] PC,
   output logic             Zero,
   output logic             retire,
   output logic             halted
);

   localparam int unsigned      IdxW     = $clog2(REG_COUNT);
   localparam bit               FullFile = (REG_COUNT == 32);
   localparam logic [WIDTH-1:0] Four     = WIDTH'(4);

   typedef enum logic [3:0] {
      StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
      StExecR, StExecI, StAluWb, StBranch, StJal, StTrap
   } state_e;

   state_e           state_q, state_d;
   logic [31:0]      ir_q;
   logic [WIDTH-1:0] a_q, b_q, alu_q, mdr_q, pc_q;
   logic             zero_q;
   logic [WIDTH-1:0] regs_q [REG_COUNT];

   logic [6:0]       opcode, funct7;
   logic [4:0]       rd, rs1, rs2;
   logic [2:0]       funct3;
   logic             is_r, is_addi, is_lw, is_sw, is_beq, is_jal;
   logic [WIDTH-1:0] imm, alu_y, pc_next, rs1_val, rs2_val, rf_wdata;
   logic             rf_we;

   assign opcode = ir_q[6:0];
   assign rd     = ir_q[11:7];
   assign funct3 = ir_q[14:12];
   assign rs1    = ir_q[19:15];
   assign rs2    = ir_q[24:20];
   assign funct7 = ir_q[31:25];

   // Instruction classification; anything not matched here traps in DECODE.
   always_comb begin
      is_r    = (opcode == 7'b0110011) &&
                ((funct7 == 7'b0000000 && (funct3 == 3'b000 || funct3 == 3'b111 ||
                                            funct3 == 3'b110 || funct3 == 3'b010)) ||
                 (funct7 == 7'b0100000 && funct3 == 3'b000));
      is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
      is_lw   = (opcode == 7'b0000011) && (funct3 == 3'b010);
      is_sw   = (opcode == 7'b0100011) && (funct3 == 3'b010);
      is_beq  = (opcode == 7'b1100011) && (funct3 == 3'b000);
      is_jal  = (opcode == 7'b1101111);
   end

   // Sign-extended immediate selected by instruction format.
   always_comb begin
      case (opcode)
         7'b0100011: imm = {{(WIDTH-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
         7'b1100011: imm = {{(WIDTH-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25],
                            ir_q[11:8], 1'b0};
         7'b1101111: imm = {{(WIDTH-21){ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20],
                            ir_q[30:21], 1'b0};
         default:    imm = {{(WIDTH-12){ir_q[31]}}, ir_q[31:20]};
      endcase
   end

   // Register file reads: x0 and out-of-range indices read as zero.
   always_comb begin
      rs1_val   = '0;
      rs2_val   = '0;
      Debug_out = '0;
      if (rs1 != 5'd0 && (FullFile || !rs1[4])) rs1_val = regs_q[rs1[IdxW-1:0]];
      if (rs2 != 5'd0 && (FullFile || !rs2[4])) rs2_val = regs_q[rs2[IdxW-1:0]];
      if (Debug_Source_select != 5'd0 && (FullFile || !Debug_Source_select[4])) begin
         Debug_out = regs_q[Debug_Source_select[IdxW-1:0]];
      end
   end

   // ALU: address/addi add by default, R-type op in EXEC_R, compare in BRANCH.
   always_comb begin
      alu_y = a_q + imm;
      if (state_q == StExecR) begin
         case (funct3)
            3'b111:  alu_y = a_q & b_q;
            3'b110:  alu_y = a_q | b_q;
            3'b010:  begin
               alu_y    = '0;
               alu_y[0] = $signed(a_q) < $signed(b_q);
            end
            default: alu_y = funct7[5] ? (a_q - b_q) : (a_q + b_q);
         endcase
      end else if (state_q == StBranch) begin
         alu_y = a_q - b_q;
      end
   end

   // Next-state logic plus memory port, retire and register write controls.
   always_comb begin
      state_d  = state_q;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mem_addr = pc_q;
      retire   = 1'b0;
      rf_we    = 1'b0;
      rf_wdata = alu_q;
      case (state_q)
         StFetch: begin
            mem_req = 1'b1;
            if (mem_ready) state_d = StDecode;
         end
         StDecode: begin
            if (is_lw || is_sw)  state_d = StMemAdr;
            else if (is_r)       state_d = StExecR;
            else if (is_addi)    state_d = StExecI;
            else if (is_beq)     state_d = StBranch;
            else if (is_jal)     state_d = StJal;
            else                 state_d = StTrap;
         end
         StMemAdr: state_d = is_lw ? StMemRd : StMemWr;
         StMemRd: begin
            mem_req  = 1'b1;
            mem_addr = alu_q;
            if (mem_ready) state_d = StMemWb;
         end
         StMemWb: begin
            retire   = 1'b1;
            rf_we    = 1'b1;
            rf_wdata = mdr_q;
            state_d  = StFetch;
         end
         StMemWr: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = alu_q;
            if (mem_ready) begin
               retire  = 1'b1;
               state_d = StFetch;
            end
         end
         StExecR, StExecI: state_d = StAluWb;
         StAluWb: begin
            retire  = 1'b1;
            rf_we   = 1'b1;
            state_d = StFetch;
         end
         StBranch: begin
            retire  = 1'b1;
            state_d = StFetch;
         end
         StJal: begin
            retire   = 1'b1;
            rf_we    = 1'b1;
            rf_wdata = pc_q + Four;
            state_d  = StFetch;
         end
         StTrap:  state_d = StTrap;
         default: state_d = StFetch;
      endcase
      // No request may escape while reset is held, even combinationally.
      if (!reset) mem_req = 1'b0;
   end

   // PC update on retirement: taken branch and jal are PC-relative.
   always_comb begin
      pc_next = pc_q + Four;
      if (state_q == StJal || (state_q == StBranch && a_q == b_q)) pc_next = pc_q + imm;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= StFetch;
      else        state_q <= state_d;
   end

   // Datapath registers: IR, operands, ALU result, memory data, PC and Zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ir_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         alu_q  <= '0;
         mdr_q  <= '0;
         pc_q   <= RESET_PC;
         zero_q <= 1'b0;
      end else begin
         if (state_q == StFetch && mem_ready) ir_q <= mem_rdata[31:0];
         if (state_q == StDecode) begin
            a_q <= rs1_val;
            b_q <= rs2_val;
         end
         if (state_q inside {StMemAdr, StExecR, StExecI}) alu_q <= alu_y;
         if (state_q == StMemRd && mem_ready) mdr_q <= mem_rdata;
         if (state_q inside {StExecR, StExecI, StBranch}) zero_q <= (alu_y == '0);
         if (retire) pc_q <= pc_next;
      end
   end

   // Architectural register file; x0 and out-of-range writes are dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(REG_COUNT); i++) regs_q[i] <= '0;
      end else if (rf_we && rd != 5'd0 && (FullFile || !rd[4])) begin
         regs_q[rd[IdxW-1:0]] <= rf_wdata;
      end
   end

   assign mem_wdata = b_q;
   assign PC        = pc_q;
   assign Zero      = zero_q;
   assign halted    = (state_q == StTrap);

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath with a wait-state memory model.
module tb_multicycle_datapath;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        mem_req, mem_we, mem_ready, retire, halted, Zero;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, Debug_out, PC;
   logic [4:0]  dbg_sel = 5'd0;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          wait_cycles = 0;
   int          wcnt;
   int          writes_seen;
   int          retire_cnt = 0;
   logic [31:0] mem [64];
   logic [31:0] init_mem [64];

   multicycle_datapath #(.WIDTH(32), .RESET_PC(32'h0), .REG_COUNT(32)) dut (
      .clk                 (clk),
      .reset               (reset),
      .mem_req             (mem_req),
      .mem_we              (mem_we),
      .mem_addr            (mem_addr),
      .mem_wdata           (mem_wdata),
      .mem_ready           (mem_ready),
      .mem_rdata           (mem_rdata),
      .Debug_Source_select (dbg_sel),
      .Debug_out           (Debug_out),
      .PC                  (PC),
      .Zero                (Zero),
      .retire              (retire),
      .halted              (halted)
   );

   always #5 clk = ~clk;

   // Memory model: reloads the program while reset is low, inserts wait_cycles
   // wait states per transfer, and commits writes with the ready cycle.
   initial begin
      mem_ready   = 1'b0;
      mem_rdata   = '0;
      wcnt        = 0;
      writes_seen = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            for (int i = 0; i < 64; i++) mem[i] = init_mem[i];
            mem_ready = 1'b0;
            wcnt      = 0;
         end else if (mem_req) begin
            if (wcnt < wait_cycles) begin
               mem_ready = 1'b0;
               wcnt++;
            end else begin
               mem_ready = 1'b1;
               wcnt      = 0;
               mem_rdata = mem[mem_addr[7:2]];
               if (mem_we) begin
                  mem[mem_addr[7:2]] = mem_wdata;
                  writes_seen++;
               end
            end
         end else begin
            mem_ready = 1'b0;
            wcnt      = 0;
         end
      end
   end

   // Retire pulse counter.
   initial forever begin
      @(negedge clk);
      if (reset === 1'b1 && retire === 1'b1) retire_cnt++;
   end

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                         input logic [4:0] rd, rs1, rs2);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] enc_addi(input logic [4:0] rd, rs1, input logic [31:0] i);
      return {i[11:0], rs1, 3'b000, rd, 7'b0010011};
   endfunction
   function automatic logic [31:0] enc_lw(input logic [4:0] rd, rs1, input logic [31:0] i);
      return {i[11:0], rs1, 3'b010, rd, 7'b0000011};
   endfunction
   function automatic logic [31:0] enc_sw(input logic [4:0] rs2, rs1, input logic [31:0] i);
      return {i[11:5], rs2, rs1, 3'b010, i[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] enc_beq(input logic [4:0] rs1, rs2, input logic [31:0] i);
      return {i[12], i[10:5], rs2, rs1, 3'b000, i[4:1], i[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [31:0] i);
      return {i[20], i[10:1], i[11], i[19:12], rd, 7'b1101111};
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 64; i++) init_mem[i] = 32'h0;
   endtask

   // Hold reset across two edges (memory reloads), release mid-cycle 1.
   task automatic start(input int waits);
      wait_cycles = waits;
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
      #1;
   endtask

   task automatic peek(input logic [4:0] idx);
      dbg_sel = idx;
      #1;
   endtask

   task automatic test_reset();
      clear_prog();
      init_mem[0] = enc_addi(5'd1, 5'd0, 32'd5);
      wait_cycles = 0;
      reset = 1'b0;
      tick(2);
      n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", mem_req); end
      n_cmp++; if (PC !== 32'h0) begin n_bad++; $display("FAIL rst_pc: got %h want 0", PC); end
      n_cmp++; if (Zero !== 1'b0) begin n_bad++; $display("FAIL rst_zero: got %b want 0", Zero); end
      n_cmp++; if (retire !== 1'b0) begin n_bad++; $display("FAIL rst_retire: got %b want 0", retire); end
      n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL rst_halted: got %b want 0", halted); end
   endtask

   task automatic test_addi();
      int base;
      base = retire_cnt;
      reset = 1'b1;
      #1;
      n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL addi_req: got %b want 1", mem_req); end
      n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL addi_addr: got %h want 0", mem_addr); end
      tick(4);
      peek(5'd1);
      n_cmp++; if (Debug_out !== 32'd5) begin n_bad++; $display("FAIL addi_x1: got %h want 5", Debug_out); end
      n_cmp++; if (PC !== 32'd4) begin n_bad++; $display("FAIL addi_pc: got %h want 4", PC); end
      n_cmp++; if (retire_cnt - base !== 1) begin n_bad++; $display("FAIL addi_retires: got %0d want 1", retire_cnt - base); end
   endtask

   task automatic test_sw_lw();
      int wbase;
      clear_prog();
      init_mem[0] = enc_addi(5'd1, 5'd0, 32'd7);
      init_mem[1] = enc_sw(5'd1, 5'd0, 32'd32);
      init_mem[2] = enc_lw(5'd2, 5'd0, 32'd32);
      start(2);
      wbase = writes_seen;
      tick(11);
      for (int k = 0; k < 3; k++) begin
         n_cmp++; if ({mem_req, mem_we} !== 2'b11) begin n_bad++; $display("FAIL sw_req_we[%0d]: got %b want 11", k, {mem_req, mem_we}); end
         n_cmp++; if (mem_addr !== 32'd32) begin n_bad++; $display("FAIL sw_addr[%0d]: got %h want 20", k, mem_addr); end
         n_cmp++; if (mem_wdata !== 32'd7) begin n_bad++; $display("FAIL sw_wdata[%0d]: got %h want 7", k, mem_wdata); end
         tick(1);
      end
      n_cmp++; if (writes_seen - wbase !== 1 || mem[8] !== 32'd7) begin n_bad++; $display("FAIL sw_commit: got %0d writes, mem %h; want 1, 7", writes_seen - wbase, mem[8]); end
      tick(8);
      n_cmp++; if ({retire, PC} !== {1'b1, 32'd8}) begin n_bad++; $display("FAIL lw_final: got retire %b pc %h want 1, 8", retire, PC); end
      tick(1);
      peek(5'd2);
      n_cmp++; if (Debug_out !== 32'd7) begin n_bad++; $display("FAIL lw_x2: got %h want 7", Debug_out); end
      n_cmp++; if (PC !== 32'd12) begin n_bad++; $display("FAIL lw_pc: got %h want c", PC); end
   endtask

   task automatic test_beq();
      clear_prog();
      init_mem[0] = enc_addi(5'd1, 5'd0, 32'd3);
      init_mem[1] = enc_addi(5'd2, 5'd0, 32'd3);
      init_mem[2] = enc_beq(5'd1, 5'd2, 32'd12);
      start(0);
      tick(10);
      n_cmp++; if ({retire, PC} !== {1'b1, 32'd8}) begin n_bad++; $display("FAIL beq_final: got retire %b pc %h want 1, 8", retire, PC); end
      tick(1);
      n_cmp++; if (PC !== 32'd20) begin n_bad++; $display("FAIL beq_taken_pc: got %h want 14", PC); end
      n_cmp++; if (Zero !== 1'b1) begin n_bad++; $display("FAIL beq_taken_zero: got %b want 1", Zero); end
      n_cmp++; if (mem_addr !== 32'd20) begin n_bad++; $display("FAIL beq_fetch_addr: got %h want 14", mem_addr); end
      // Not taken, with Zero set by a preceding zero result.
      clear_prog();
      init_mem[0] = enc_addi(5'd1, 5'd0, 32'd3);
      init_mem[1] = enc_addi(5'd2, 5'd0, 32'd4);
      init_mem[2] = enc_addi(5'd3, 5'd0, 32'd0);
      init_mem[3] = enc_beq(5'd1, 5'd2, 32'd12);
      start(0);
      tick(12);
      n_cmp++; if (Zero !== 1'b1) begin n_bad++; $display("FAIL addi_zero: got %b want 1", Zero); end
      tick(3);
      n_cmp++; if (PC !== 32'd16) begin n_bad++; $display("FAIL beq_nt_pc: got %h want 10", PC); end
      n_cmp++; if (Zero !== 1'b0) begin n_bad++; $display("FAIL beq_nt_zero: got %b want 0", Zero); end
   endtask

   task automatic test_jal();
      clear_prog();
      init_mem[0] = enc_jal(5'd0, 32'd16);
      init_mem[4] = enc_jal(5'd5, 32'd16);
      start(0);
      tick(2);
      n_cmp++; if (retire !== 1'b1) begin n_bad++; $display("FAIL jal_retire: got %b want 1", retire); end
      tick(1);
      n_cmp++; if (PC !== 32'h10) begin n_bad++; $display("FAIL jal0_pc: got %h want 10", PC); end
      peek(5'd0);
      n_cmp++; if (Debug_out !== 32'h0) begin n_bad++; $display("FAIL jal_x0: got %h want 0", Debug_out); end
      tick(3);
      peek(5'd5);
      n_cmp++; if (Debug_out !== 32'h14) begin n_bad++; $display("FAIL jal_x5: got %h want 14", Debug_out); end
      n_cmp++; if (PC !== 32'h20) begin n_bad++; $display("FAIL jal5_pc: got %h want 20", PC); end
      // PC wraps modulo 2^32 in both directions.
      clear_prog();
      init_mem[0]  = enc_jal(5'd1, 32'hFFFF_FFFC);
      init_mem[63] = enc_jal(5'd0, 32'd8);
      start(0);
      tick(3);
      peek(5'd1);
      n_cmp++; if (PC !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_pc_back: got %h want fffffffc", PC); end
      n_cmp++; if (Debug_out !== 32'd4) begin n_bad++; $display("FAIL wrap_x1: got %h want 4", Debug_out); end
      tick(3);
      n_cmp++; if (PC !== 32'd4) begin n_bad++; $display("FAIL wrap_pc_fwd: got %h want 4", PC); end
   endtask

   task automatic test_alu_trap();
      bit bad;
      clear_prog();
      init_mem[0] = enc_addi(5'd2, 5'd0, 32'd1);
      init_mem[1] = enc_r(7'h20, 3'b000, 5'd3, 5'd1, 5'd2);
      init_mem[2] = enc_r(7'h00, 3'b010, 5'd4, 5'd3, 5'd0);
      init_mem[3] = enc_r(7'h00, 3'b000, 5'd5, 5'd2, 5'd2);
      init_mem[4] = enc_r(7'h00, 3'b110, 5'd6, 5'd5, 5'd2);
      init_mem[5] = enc_r(7'h00, 3'b111, 5'd7, 5'd6, 5'd5);
      init_mem[6] = 32'h0000_007F;
      start(0);
      tick(24);
      n_cmp++; if (PC !== 32'd24) begin n_bad++; $display("FAIL alu_pc: got %h want 18", PC); end
      peek(5'd3);
      n_cmp++; if (Debug_out !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL sub_x3: got %h want ffffffff", Debug_out); end
      peek(5'd4);
      n_cmp++; if (Debug_out !== 32'd1) begin n_bad++; $display("FAIL slt_x4: got %h want 1", Debug_out); end
      peek(5'd5);
      n_cmp++; if (Debug_out !== 32'd2) begin n_bad++; $display("FAIL add_x5: got %h want 2", Debug_out); end
      peek(5'd6);
      n_cmp++; if (Debug_out !== 32'd3) begin n_bad++; $display("FAIL or_x6: got %h want 3", Debug_out); end
      peek(5'd7);
      n_cmp++; if (Debug_out !== 32'd2) begin n_bad++; $display("FAIL and_x7: got %h want 2", Debug_out); end
      tick(2);
      n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL trap_halted: got %b want 1", halted); end
      bad = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (mem_req !== 1'b0 || PC !== 32'd24 || halted !== 1'b1 || retire !== 1'b0) bad = 1'b1;
         tick(1);
      end
      n_cmp++; if (bad) begin n_bad++; $display("FAIL trap_hold: got req %b pc %h halted %b want 0, 18, 1", mem_req, PC, halted); end
   endtask

   task automatic test_abort();
      int wbase;
      clear_prog();
      init_mem[0] = enc_addi(5'd1, 5'd0, 32'd9);
      init_mem[1] = enc_sw(5'd1, 5'd0, 32'd32);
      init_mem[8] = 32'hDEAD_BEEF;
      start(0);
      tick(6);
      wait_cycles = 1000;
      tick(1);
      wbase = writes_seen;
      n_cmp++; if ({mem_req, mem_we} !== 2'b11) begin n_bad++; $display("FAIL abort_memwr: got %b want 11", {mem_req, mem_we}); end
      peek(5'd1);
      n_cmp++; if (Debug_out !== 32'd9) begin n_bad++; $display("FAIL abort_x1_pre: got %h want 9", Debug_out); end
      tick(1);
      reset = 1'b0;
      #1;
      n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL abort_req: got %b want 0", mem_req); end
      n_cmp++; if (writes_seen !== wbase || mem[8] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL abort_nowrite: got %0d writes, mem %h", writes_seen - wbase, mem[8]); end
      peek(5'd1);
      n_cmp++; if (Debug_out !== 32'd0) begin n_bad++; $display("FAIL abort_x1_clr: got %h want 0", Debug_out); end
      n_cmp++; if (PC !== 32'd0) begin n_bad++; $display("FAIL abort_pc: got %h want 0", PC); end
      tick(2);
      wait_cycles = 0;
      reset = 1'b1;
      #1;
      n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'd0}) begin n_bad++; $display("FAIL abort_refetch: got req %b addr %h want 1, 0", mem_req, mem_addr); end
      tick(4);
      peek(5'd1);
      n_cmp++; if (Debug_out !== 32'd9) begin n_bad++; $display("FAIL abort_rerun: got %h want 9", Debug_out); end
   endtask

   initial begin
      clear_prog();
      test_reset();
      test_addi();
      test_sw_lw();
      test_beq();
      test_jal();
      test_alu_trap();
      test_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
